// File: rtl/carbon_irq_sched.sv
// Priority interrupt scheduler: latches/masks sources, presents one vector with valid/ack, tracks in-service until EOI.
// Optional macro CARBON_IRQ_SCHED_NEST_EN enables priority nesting; undefined means one interrupt in service at a time.
module carbon_irq_sched #(
    parameter int         N_SRC    = 8,
    parameter logic [7:0] VEC_BASE = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_SRC-1:0]  i_src_irq,
    input  logic              i_reg_valid,
    output logic              o_reg_ready,
    input  logic              i_reg_write,
    input  logic [4:0]        i_reg_addr,
    input  logic [31:0]       i_reg_wdata,
    output logic [31:0]       o_reg_rdata,
    output logic              o_reg_rvalid,
    output logic              o_irq_valid,
    output logic [7:0]        o_irq_vector,
    input  logic              i_irq_ack,
    output logic              o_irq_busy
);
    typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

    state_t               r_state, w_state_next;
    logic                 r_ctrl_en;
    logic [15:0]          r_mask;
    logic [N_SRC-1:0]     r_edge, r_latch, r_prev, r_inservice;
    logic [2*N_SRC-1:0]   r_prio;
    logic [7:0]           r_vector;
    logic [3:0]           r_idx;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;

    logic [N_SRC-1:0]     w_pending, w_elig;
    logic [N_SRC-1:0]     w_latch_set, w_latch_clr, w_latch_next;
    logic [N_SRC-1:0]     w_ack_vec, w_eoi_vec;
    logic                 w_win_found, w_is_any, w_fire, w_load, w_ack_take;
    logic [3:0]           w_win_idx, w_is_idx;
    logic [1:0]           w_win_prio, w_is_prio;
    logic                 w_wr, w_rd;
    logic [2:0]           w_sel;
    logic [31:0]          w_rdata;
    logic                 w_unused_bits;

    assign w_wr  = i_reg_valid & i_reg_write;
    assign w_rd  = i_reg_valid & ~i_reg_write;
    assign w_sel = i_reg_addr[4:2];
    assign w_unused_bits = ^{i_reg_wdata, i_reg_addr[1:0]};

    assign w_pending = (r_edge & r_latch) | (~r_edge & i_src_irq);
    assign w_elig    = w_pending & ~r_mask[N_SRC-1:0] & {N_SRC{r_ctrl_en}};

    // Strict '>' keeps the lowest index on equal priority.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_prio  = '0;
        w_is_any    = 1'b0;
        w_is_idx    = '0;
        w_is_prio   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_elig[i] && (!w_win_found || r_prio[2*i +: 2] > w_win_prio)) begin
                w_win_found = 1'b1;
                w_win_idx   = 4'(i);
                w_win_prio  = r_prio[2*i +: 2];
            end
            if (r_inservice[i] && (!w_is_any || r_prio[2*i +: 2] > w_is_prio)) begin
                w_is_any  = 1'b1;
                w_is_idx  = 4'(i);
                w_is_prio = r_prio[2*i +: 2];
            end
        end
    end

`ifdef CARBON_IRQ_SCHED_NEST_EN
    assign w_fire = w_win_found && (!w_is_any || w_win_prio > w_is_prio);
`else
    assign w_fire = w_win_found && !w_is_any;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_next = ST_PRESENT;
                    w_load       = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (i_irq_ack) begin
                    w_state_next = ST_IDLE;
                    w_ack_take   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
        assign w_latch_set[gi] = r_edge[gi] & i_src_irq[gi] & ~r_prev[gi];
        assign w_ack_vec[gi]   = w_ack_take & (r_idx == 4'(gi));
        assign w_eoi_vec[gi]   = w_wr & (w_sel == 3'd6) & w_is_any & (w_is_idx == 4'(gi));
        assign w_latch_clr[gi] = (w_wr & (w_sel == 3'd4) & i_reg_wdata[gi]) | w_ack_vec[gi];
    end
    // A new edge in the same cycle as a clear wins.
    assign w_latch_next = w_latch_set | (r_latch & ~w_latch_clr);

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            3'd0:    w_rdata = {31'b0, r_ctrl_en};
            3'd1:    w_rdata = 32'(r_mask);
            3'd2:    w_rdata = 32'(r_edge);
            3'd3:    w_rdata = 32'(r_prio);
            3'd4:    w_rdata = 32'(w_pending);
            3'd5:    w_rdata = 32'(r_inservice);
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl_en   <= 1'b0;
            r_mask      <= '1;
            r_edge      <= '0;
            r_prio      <= '0;
            r_latch     <= '0;
            r_prev      <= '0;
            r_inservice <= '0;
            r_vector    <= '0;
            r_idx       <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            r_prev      <= i_src_irq;
            r_latch     <= w_latch_next;
            r_inservice <= (r_inservice & ~w_eoi_vec) | w_ack_vec;
            r_rvalid    <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
            if (w_load) begin
                r_vector <= VEC_BASE + {4'b0, w_win_idx};
                r_idx    <= w_win_idx;
            end
            if (w_wr) begin
                case (w_sel)
                    3'd0:    r_ctrl_en <= i_reg_wdata[0];
                    3'd1:    r_mask    <= i_reg_wdata[15:0];
                    3'd2:    r_edge    <= i_reg_wdata[N_SRC-1:0];
                    3'd3:    r_prio    <= i_reg_wdata[2*N_SRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign o_reg_ready  = 1'b1;
    assign o_reg_rdata  = r_rdata;
    assign o_reg_rvalid = r_rvalid;
    assign o_irq_valid  = (r_state == ST_PRESENT);
    assign o_irq_vector = r_vector;
    assign o_irq_busy   = |r_inservice;
endmodule

// File: tb/tb_carbon_irq_sched.sv
// Bench for carbon_irq_sched: directed table, multi-cycle corner sequences, then random traffic against a reference model.
module tb_carbon_irq_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src;
    logic        reg_valid, reg_write, irq_ack;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ready, reg_rvalid, irq_valid, irq_busy;
    logic [31:0] reg_rdata;
    logic [7:0]  irq_vector;

    int n_tests = 0;
    int n_fail  = 0;

    carbon_irq_sched #(.N_SRC(8), .VEC_BASE(8'h20)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_irq(src),
        .i_reg_valid(reg_valid), .o_reg_ready(reg_ready), .i_reg_write(reg_write),
        .i_reg_addr(reg_addr), .i_reg_wdata(reg_wdata),
        .o_reg_rdata(reg_rdata), .o_reg_rvalid(reg_rvalid),
        .o_irq_valid(irq_valid), .o_irq_vector(irq_vector),
        .i_irq_ack(irq_ack), .o_irq_busy(irq_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic        wr, rd;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        ack;
        logic        exp_valid;
        logic [7:0]  exp_vec;
        logic        exp_busy;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl[19];

    // Reference model state
    bit        m_en, m_pres, m_rvalid;
    bit [15:0] m_mask, m_prio;
    bit [7:0]  m_edge, m_latch, m_prev, m_ins, m_vec;
    bit [31:0] m_rdata;
    int        m_idx;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_valid = 1; reg_write = 1; reg_addr = a; reg_wdata = d;
        tick();
        reg_valid = 0; reg_write = 0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        reg_valid = 1; reg_write = 0; reg_addr = a;
        tick();
        reg_valid = 0;
        chk({name, " rvalid"}, 32'(reg_rvalid), 32'd1);
        chk(name, reg_rdata, exp);
    endtask

    task automatic do_ack();
        irq_ack = 1; tick(); irq_ack = 0;
    endtask

    task automatic chk_irq(input string name, input logic v, input logic [7:0] vec, input logic b);
        chk({name, " valid"}, 32'(irq_valid), 32'(v));
        if (v) chk({name, " vector"}, 32'(irq_vector), 32'(vec));
        chk({name, " busy"}, 32'(irq_busy), 32'(b));
    endtask

    task automatic do_reset();
        rst_n = 0; src = 0; reg_valid = 0; reg_write = 0; reg_addr = 0; reg_wdata = 0; irq_ack = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic model_reset();
        m_en = 0; m_pres = 0; m_rvalid = 0; m_mask = 16'hFFFF; m_prio = 0;
        m_edge = 0; m_latch = 0; m_prev = 0; m_ins = 0; m_vec = 0; m_rdata = 0; m_idx = 0;
    endtask

    // Ranking key: higher priority first, then lower index.
    function automatic int key_of(int i);
        return int'(m_prio[2*i +: 2]) * 64 - i;
    endfunction

    task automatic model_step(input bit [7:0] s, input bit v, input bit w, input bit [4:0] a,
                              input bit [31:0] d, input bit k);
        bit [7:0] pend, lat_n, ins_n;
        int best, ins_best;
        bit allowed, fire, take;
        for (int i = 0; i < 8; i++) pend[i] = m_edge[i] ? m_latch[i] : s[i];
        best = -1; ins_best = -1;
        for (int i = 0; i < 8; i++) begin
            if (pend[i] && !m_mask[i] && m_en && (best < 0 || key_of(i) > key_of(best))) best = i;
            if (m_ins[i] && (ins_best < 0 || key_of(i) > key_of(ins_best))) ins_best = i;
        end
`ifdef CARBON_IRQ_SCHED_NEST_EN
        allowed = (ins_best < 0) || (best >= 0 && m_prio[2*best +: 2] > m_prio[2*ins_best +: 2]);
`else
        allowed = (m_ins == 0);
`endif
        fire = !m_pres && best >= 0 && allowed;
        take = m_pres && k;
        m_rvalid = v && !w;
        if (v && !w) begin
            case (a[4:2])
                3'd0: m_rdata = {31'b0, m_en};
                3'd1: m_rdata = {16'b0, m_mask};
                3'd2: m_rdata = {24'b0, m_edge};
                3'd3: m_rdata = {16'b0, m_prio};
                3'd4: m_rdata = {24'b0, pend};
                3'd5: m_rdata = {24'b0, m_ins};
                default: m_rdata = 0;
            endcase
        end
        ins_n = m_ins;
        if (v && w && a[4:2] == 3'd6 && ins_best >= 0) ins_n[ins_best] = 0;
        if (take) ins_n[m_idx] = 1;
        for (int i = 0; i < 8; i++) begin
            bit clr, set;
            clr = (v && w && a[4:2] == 3'd4 && d[i]) || (take && m_idx == i);
            set = m_edge[i] && s[i] && !m_prev[i];
            lat_n[i] = set | (m_latch[i] & !clr);
        end
        if (fire) begin
            m_pres = 1; m_vec = 8'h20 + 8'(best); m_idx = best;
        end else if (take) begin
            m_pres = 0;
        end
        m_ins = ins_n; m_latch = lat_n; m_prev = s;
        if (v && w) begin
            case (a[4:2])
                3'd0: m_en = d[0];
                3'd1: m_mask = d[15:0];
                3'd2: m_edge = d[7:0];
                3'd3: m_prio = d[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit [7:0] s, input bit v, input bit w, input bit [4:0] a,
                        input bit [31:0] d, input bit k, input int cyc);
        src = s; reg_valid = v; reg_write = w; reg_addr = a; reg_wdata = d; irq_ack = k;
        @(posedge clk);
        model_step(s, v, w, a, d, k);
        #1;
        n_tests++;
        if (irq_valid !== m_pres || irq_vector !== m_vec || irq_busy !== (m_ins != 0) ||
            reg_rvalid !== m_rvalid || (m_rvalid && reg_rdata !== m_rdata)) begin
            n_fail++;
            $display("FAIL rand cyc %0d: got v=%b vec=%h busy=%b rv=%b rd=%h, expected v=%b vec=%h busy=%b rv=%b rd=%h",
                     cyc, irq_valid, irq_vector, irq_busy, reg_rvalid, reg_rdata,
                     m_pres, m_vec, (m_ins != 0), m_rvalid, m_rdata);
        end
    endtask

    initial begin
        bit [7:0] rs;
        //          src   wr rd addr   wdata    ack v  vec    busy rv rdata
        tbl[0]  = '{8'h00, 1, 0, 5'h00, 32'h1,   0, 0, 8'h00, 0, 0, 32'h0};
        tbl[1]  = '{8'h00, 1, 0, 5'h04, 32'h0,   0, 0, 8'h00, 0, 0, 32'h0};
        tbl[2]  = '{8'h08, 0, 0, 5'h00, 32'h0,   0, 1, 8'h23, 0, 0, 32'h0};
        tbl[3]  = '{8'h08, 0, 0, 5'h00, 32'h0,   0, 1, 8'h23, 0, 0, 32'h0};
        tbl[4]  = '{8'h08, 0, 0, 5'h00, 32'h0,   1, 0, 8'h23, 1, 0, 32'h0};
        tbl[5]  = '{8'h08, 0, 1, 5'h14, 32'h0,   0, 0, 8'h23, 1, 1, 32'h08};
        tbl[6]  = '{8'h00, 1, 0, 5'h18, 32'h0,   0, 0, 8'h23, 0, 0, 32'h0};
        tbl[7]  = '{8'h00, 0, 1, 5'h14, 32'h0,   0, 0, 8'h23, 0, 1, 32'h0};
        tbl[8]  = '{8'h00, 1, 0, 5'h0C, 32'hC04, 0, 0, 8'h23, 0, 0, 32'h0};
        tbl[9]  = '{8'h22, 0, 0, 5'h00, 32'h0,   0, 1, 8'h25, 0, 0, 32'h0};
        tbl[10] = '{8'h02, 0, 0, 5'h00, 32'h0,   1, 0, 8'h25, 1, 0, 32'h0};
        tbl[11] = '{8'h02, 0, 0, 5'h00, 32'h0,   0, 0, 8'h25, 1, 0, 32'h0};
        tbl[12] = '{8'h02, 1, 0, 5'h18, 32'h0,   0, 0, 8'h25, 0, 0, 32'h0};
        tbl[13] = '{8'h02, 0, 0, 5'h00, 32'h0,   0, 1, 8'h21, 0, 0, 32'h0};
        tbl[14] = '{8'h00, 0, 0, 5'h00, 32'h0,   1, 0, 8'h21, 1, 0, 32'h0};
        tbl[15] = '{8'h00, 1, 0, 5'h18, 32'h0,   0, 0, 8'h21, 0, 0, 32'h0};
        tbl[16] = '{8'h00, 1, 0, 5'h18, 32'h0,   0, 0, 8'h21, 0, 0, 32'h0};
        tbl[17] = '{8'h00, 0, 1, 5'h1C, 32'h0,   0, 0, 8'h21, 0, 1, 32'h0};
        tbl[18] = '{8'h00, 0, 1, 5'h0E, 32'h0,   0, 0, 8'h21, 0, 1, 32'hC04};

        do_reset();
        chk_irq("reset", 0, 8'h00, 0);
        chk("reset vector", 32'(irq_vector), 32'h0);
        chk("reset rvalid", 32'(reg_rvalid), 32'h0);
        chk("reset rdata", reg_rdata, 32'h0);
        chk("reg_ready", 32'(reg_ready), 32'h1);
        rd_chk("reset MASK", 5'h04, 32'h0000FFFF);
        rd_chk("reset CTRL", 5'h00, 32'h0);

        for (int r = 0; r < 19; r++) begin
            src = tbl[r].src; reg_valid = tbl[r].wr | tbl[r].rd; reg_write = tbl[r].wr;
            reg_addr = tbl[r].addr; reg_wdata = tbl[r].wdata; irq_ack = tbl[r].ack;
            tick();
            reg_valid = 0; reg_write = 0; irq_ack = 0;
            chk($sformatf("tbl%0d valid", r), 32'(irq_valid), 32'(tbl[r].exp_valid));
            chk($sformatf("tbl%0d vector", r), 32'(irq_vector), 32'(tbl[r].exp_vec));
            chk($sformatf("tbl%0d busy", r), 32'(irq_busy), 32'(tbl[r].exp_busy));
            chk($sformatf("tbl%0d rvalid", r), 32'(reg_rvalid), 32'(tbl[r].exp_rvalid));
            if (tbl[r].exp_rvalid) chk($sformatf("tbl%0d rdata", r), reg_rdata, tbl[r].exp_rdata);
        end

        // Nesting: src2 in service at PRIO 1, src6 requests at PRIO 2
        wr(5'h0C, 32'h2010);
        src = 8'h04; tick();
        chk_irq("nest src2", 1, 8'h22, 0);
        src = 8'h40; do_ack();
        chk_irq("nest ack2", 0, 8'h00, 1);
        tick();
`ifdef CARBON_IRQ_SCHED_NEST_EN
        chk_irq("nest pre", 1, 8'h26, 1);
        rd_chk("nest INS a", 5'h14, 32'h04);
        src = 8'h00; do_ack();
        rd_chk("nest INS b", 5'h14, 32'h44);
        wr(5'h18, 32'h0);
        rd_chk("nest INS c", 5'h14, 32'h04);
        wr(5'h18, 32'h0);
        rd_chk("nest INS d", 5'h14, 32'h00);
`else
        chk_irq("nonest blocked", 0, 8'h00, 1);
        rd_chk("nonest INS a", 5'h14, 32'h04);
        wr(5'h18, 32'h0);
        chk_irq("nonest eoi", 0, 8'h00, 0);
        tick();
        chk_irq("nonest src6", 1, 8'h26, 0);
        src = 8'h00; do_ack();
        rd_chk("nonest INS b", 5'h14, 32'h40);
        wr(5'h18, 32'h0);
        chk_irq("nonest done", 0, 8'h00, 0);
`endif

        // Edge source pulsed while masked
        wr(5'h04, 32'hFF);
        wr(5'h08, 32'h01);
        src = 8'h01; tick();
        src = 8'h00; tick();
        rd_chk("edge PENDING", 5'h10, 32'h01);
        chk_irq("edge masked", 0, 8'h00, 0);
        wr(5'h04, 32'hFE);
        chk_irq("edge unmask", 0, 8'h00, 0);
        tick();
        chk_irq("edge present", 1, 8'h20, 0);
        do_ack();
        rd_chk("edge PENDING clr", 5'h10, 32'h00);
        wr(5'h18, 32'h0);

        // Source drops and gets masked while presented
        wr(5'h08, 32'h00);
        wr(5'h04, 32'h00);
        src = 8'h10; tick();
        chk_irq("hold present", 1, 8'h24, 0);
        src = 8'h00; wr(5'h04, 32'hFF);
        chk_irq("hold masked", 1, 8'h24, 0);
        tick();
        chk_irq("hold later", 1, 8'h24, 0);
        do_ack();
        chk_irq("hold ack", 0, 8'h00, 1);
        rd_chk("hold INS", 5'h14, 32'h10);
        wr(5'h18, 32'h0);

        // Asynchronous reset during PRESENT
        wr(5'h04, 32'h00);
        src = 8'h08; tick();
        chk_irq("rst pre", 1, 8'h23, 0);
        #2 rst_n = 0;
        #1;
        chk("rst async valid", 32'(irq_valid), 32'h0);
        chk("rst async vector", 32'(irq_vector), 32'h0);
        src = 8'h00;
        @(posedge clk); #1 rst_n = 1;
        rd_chk("rst MASK", 5'h04, 32'h0000FFFF);
        rd_chk("rst CTRL", 5'h00, 32'h0);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        step(8'h00, 1, 1, 5'h00, 32'h1, 0, 0);
        step(8'h00, 1, 1, 5'h04, 32'h0, 0, 1);
        rs = 0;
        for (int c = 2; c < 700; c++) begin
            bit v, w, k;
            bit [4:0] a;
            bit [31:0] d;
            int word;
            if ($urandom_range(0, 3) == 0) rs = 8'($urandom);
            k = ($urandom_range(0, 2) == 0);
            v = 0; w = 0; a = 0; d = 0;
            if ($urandom_range(0, 5) == 0) begin
                v = 1; w = 1; a = 5'h18; d = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                word = $urandom_range(0, 7);
                v = 1; w = $urandom_range(0, 1) == 1;
                a = {3'(word), 2'($urandom)};
                d = $urandom;
                if (word == 0) d = {31'($urandom), ($urandom_range(0, 3) != 0)};
                if (word == 1) d = $urandom & $urandom & $urandom;
            end
            step(rs, v, w, a, d, k, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
